// File: rtl/mem_port_arbiter.sv
// Single memory port shared between instruction fetch and load/store.
// One outstanding transaction; LS has priority, bounded by a fairness streak counter.
module mem_port_arbiter #(
    parameter int ADDR_W        = 32,
    parameter int DATA_W        = 32,
    parameter int MAX_LS_STREAK = 2
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_gnt,
    output logic                if_rvalid,
    output logic [DATA_W-1:0]   if_rdata,

    input  logic                ls_req,
    input  logic                ls_we,
    input  logic [DATA_W/8-1:0] ls_be,
    input  logic [ADDR_W-1:0]   ls_addr,
    input  logic [DATA_W-1:0]   ls_wdata,
    output logic                ls_gnt,
    output logic                ls_rvalid,
    output logic [DATA_W-1:0]   ls_rdata,

    output logic                mem_req,
    output logic                mem_we,
    output logic [DATA_W/8-1:0] mem_be,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic                mem_gnt,
    input  logic                mem_rvalid,
    input  logic [DATA_W-1:0]   mem_rdata
);

    localparam int STREAK_W = (MAX_LS_STREAK < 1) ? 1 : $clog2(MAX_LS_STREAK + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_LS_STREAK);

    typedef enum logic [2:0] {
        IDLE,
        HOLD_IF,
        HOLD_LS,
        WAIT_IF,
        WAIT_LS
    } state_t;

    state_t              state_q, state_d;
    logic [STREAK_W-1:0] streak_q, streak_d;
    logic                sel_if, sel_ls;
    logic                fair_block;

    // With a zero limit the counter never moves, so LS keeps strict priority.
    assign fair_block = (MAX_LS_STREAK != 0) && (streak_q == STREAK_MAX);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            streak_q <= '0;
        end else begin
            state_q  <= state_d;
            streak_q <= streak_d;
        end
    end

    always_comb begin
        // NOTE: every output and next-state gets a default first, so no path can infer a latch.
        state_d   = state_q;
        streak_d  = streak_q;
        sel_if    = 1'b0;
        sel_ls    = 1'b0;
        if_gnt    = 1'b0;
        if_rvalid = 1'b0;
        if_rdata  = '0;
        ls_gnt    = 1'b0;
        ls_rvalid = 1'b0;
        ls_rdata  = '0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_be    = '0;
        mem_addr  = '0;
        mem_wdata = '0;

        case (state_q)
            IDLE: begin
                if (ls_req && !(if_req && fair_block)) begin
                    sel_ls = 1'b1;
                end else if (if_req) begin
                    sel_if = 1'b1;
                end
            end
            // A held owner is locked in; dropping its request abandons the slot.
            HOLD_IF: begin
                if (if_req) sel_if = 1'b1;
                else        state_d = IDLE;
            end
            HOLD_LS: begin
                if (ls_req) sel_ls = 1'b1;
                else        state_d = IDLE;
            end
            WAIT_IF: begin
                if (mem_rvalid) begin
                    if_rvalid = 1'b1;
                    if_rdata  = mem_rdata;
                    state_d   = IDLE;
                end
            end
            WAIT_LS: begin
                if (mem_rvalid) begin
                    ls_rvalid = 1'b1;
                    ls_rdata  = mem_rdata;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (sel_if) begin
            mem_req  = 1'b1;
            mem_be   = '1;
            mem_addr = if_addr;
            if (mem_gnt) begin
                if_gnt   = 1'b1;
                state_d  = WAIT_IF;
                streak_d = '0;
            end else begin
                state_d  = HOLD_IF;
            end
        end

        if (sel_ls) begin
            mem_req   = 1'b1;
            mem_we    = ls_we;
            mem_be    = ls_be;
            mem_addr  = ls_addr;
            mem_wdata = ls_wdata;
            if (mem_gnt) begin
                ls_gnt  = 1'b1;
                state_d = WAIT_LS;
                // The streak only counts LS wins that actually made fetch wait.
                if (!if_req)                     streak_d = '0;
                else if (streak_q != STREAK_MAX) streak_d = streak_q + STREAK_W'(1);
            end else begin
                state_d = HOLD_LS;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: vector table, directed corner sequences,
// and a randomized run compared against a transaction-level reference model.
module tb_mem_port_arbiter;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int BW   = DW / 8;
    localparam int MAXS = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req, if_gnt, if_rvalid;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          ls_req, ls_we, ls_gnt, ls_rvalid;
    logic [BW-1:0] ls_be;
    logic [AW-1:0] ls_addr;
    logic [DW-1:0] ls_wdata, ls_rdata;
    logic          mem_req, mem_we, mem_gnt, mem_rvalid;
    logic [BW-1:0] mem_be;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_LS_STREAK(MAXS)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .ls_req(ls_req), .ls_we(ls_we), .ls_be(ls_be), .ls_addr(ls_addr),
        .ls_wdata(ls_wdata), .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata)
    );

    typedef struct packed {
        logic          if_req;
        logic [AW-1:0] if_addr;
        logic          ls_req;
        logic          ls_we;
        logic [BW-1:0] ls_be;
        logic [AW-1:0] ls_addr;
        logic [DW-1:0] ls_wdata;
        logic          mem_gnt;
        logic          mem_rvalid;
        logic [DW-1:0] mem_rdata;
    } in_t;

    typedef struct packed {
        logic          if_gnt;
        logic          if_rvalid;
        logic [DW-1:0] if_rdata;
        logic          ls_gnt;
        logic          ls_rvalid;
        logic [DW-1:0] ls_rdata;
        logic          mem_req;
        logic          mem_we;
        logic [BW-1:0] mem_be;
        logic [AW-1:0] mem_addr;
        logic [DW-1:0] mem_wdata;
    } out_t;

    typedef struct {
        in_t  in;
        out_t exp;
    } vec_t;

    out_t act_w, last_act;
    assign act_w = {if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata,
                    mem_req, mem_we, mem_be, mem_addr, mem_wdata};

    int n_vec = 0;
    int n_err = 0;
    int n_viol = 0;
    bit viol_ok = 1'b0;

    // Reference model: one outstanding transaction, a locked owner while the bus stalls.
    bit m_busy, m_locked, m_ls;
    int m_streak;
    bit e_have, e_ls, e_acc;

    task automatic model_reset();
        m_busy = 0; m_locked = 0; m_ls = 0; m_streak = 0;
        e_have = 0; e_ls = 0; e_acc = 0;
    endtask

    task automatic model_eval(input in_t i, output out_t o);
        o = '0; e_have = 0; e_ls = 0; e_acc = 0;
        if (m_busy) begin
            if (i.mem_rvalid) begin
                if (m_ls) begin o.ls_rvalid = 1; o.ls_rdata = i.mem_rdata; end
                else      begin o.if_rvalid = 1; o.if_rdata = i.mem_rdata; end
            end
        end else begin
            if (m_locked) begin
                e_ls = m_ls;
                e_have = m_ls ? i.ls_req : i.if_req;
            end else if (i.ls_req && !(i.if_req && MAXS != 0 && m_streak >= MAXS)) begin
                e_ls = 1; e_have = 1;
            end else if (i.if_req) begin
                e_ls = 0; e_have = 1;
            end
            if (e_have) begin
                o.mem_req = 1;
                if (e_ls) begin
                    o.mem_we = i.ls_we; o.mem_be = i.ls_be;
                    o.mem_addr = i.ls_addr; o.mem_wdata = i.ls_wdata;
                end else begin
                    o.mem_be = '1; o.mem_addr = i.if_addr;
                end
                e_acc = i.mem_gnt;
                if (e_acc) begin
                    if (e_ls) o.ls_gnt = 1;
                    else      o.if_gnt = 1;
                end
            end
        end
    endtask

    task automatic model_commit(input in_t i);
        if (m_busy) begin
            if (i.mem_rvalid) m_busy = 0;
        end else if (e_have && e_acc) begin
            m_busy = 1; m_locked = 0; m_ls = e_ls;
            if (e_ls && i.if_req) m_streak = (m_streak < MAXS) ? m_streak + 1 : MAXS;
            else                  m_streak = 0;
        end else if (e_have) begin
            m_locked = 1; m_ls = e_ls;
        end else begin
            m_locked = 0;
        end
    endtask

    task automatic drive(input in_t i);
        if_req = i.if_req; if_addr = i.if_addr;
        ls_req = i.ls_req; ls_we = i.ls_we; ls_be = i.ls_be;
        ls_addr = i.ls_addr; ls_wdata = i.ls_wdata;
        mem_gnt = i.mem_gnt; mem_rvalid = i.mem_rvalid; mem_rdata = i.mem_rdata;
    endtask

    // One clock: inputs applied just after a rising edge, outputs sampled at the falling edge.
    task automatic cycle(input in_t i, output out_t exp);
        drive(i);
        @(negedge clk);
        if (m_locked && !m_busy && !(m_ls ? i.ls_req : i.if_req)) begin
            n_viol++;
            if (!viol_ok) begin
                n_vec++; n_err++;
                $display("FAIL protocol: held requester dropped req (if_req=%0b ls_req=%0b)",
                         i.if_req, i.ls_req);
            end
        end
        model_eval(i, exp);
        last_act = act_w;
        @(posedge clk);
        model_commit(i);
        #1;
    endtask

    task automatic check(input string name, input out_t got, input out_t want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    task automatic check_val(input string name, input int got, input int want);
        n_vec++;
        if (got != want) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, got, want);
        end
    endtask

    function automatic in_t ii(logic ireq, logic [AW-1:0] ia, logic lreq, logic lwe,
                               logic [BW-1:0] lbe, logic [AW-1:0] la, logic [DW-1:0] lwd,
                               logic g, logic rv, logic [DW-1:0] rd);
        in_t t;
        t.if_req = ireq; t.if_addr = ia; t.ls_req = lreq; t.ls_we = lwe; t.ls_be = lbe;
        t.ls_addr = la; t.ls_wdata = lwd; t.mem_gnt = g; t.mem_rvalid = rv; t.mem_rdata = rd;
        return t;
    endfunction

    function automatic out_t oo(logic ig, logic irv, logic [DW-1:0] ird, logic lg, logic lrv,
                                logic [DW-1:0] lrd, logic rq, logic we, logic [BW-1:0] be,
                                logic [AW-1:0] a, logic [DW-1:0] wd);
        out_t t;
        t.if_gnt = ig; t.if_rvalid = irv; t.if_rdata = ird; t.ls_gnt = lg; t.ls_rvalid = lrv;
        t.ls_rdata = lrd; t.mem_req = rq; t.mem_we = we; t.mem_be = be; t.mem_addr = a;
        t.mem_wdata = wd;
        return t;
    endfunction

    task automatic do_reset();
        drive('0);
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        check("reset_outputs", act_w, '0);
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    vec_t tbl[12];
    out_t mexp, zero_o;
    in_t  cur;
    int   rv_delay;
    logic [1:0] order_exp[12];

    initial begin
        zero_o = '0;
        rst = 1'b1;
        drive('0);
        model_reset();

        // Vector table: IF read, spurious response, store vs fetch, load.
        tbl[0]  = '{ii(1, 32'h100, 0, 0, 4'h0, 0, 0, 1, 0, 0),
                    oo(1, 0, 0, 0, 0, 0, 1, 0, 4'hF, 32'h100, 0)};
        tbl[1]  = '{ii(0, 0, 0, 0, 4'h0, 0, 0, 0, 0, 0), zero_o};
        tbl[2]  = '{ii(0, 0, 0, 0, 4'h0, 0, 0, 0, 1, 32'h13),
                    oo(0, 1, 32'h13, 0, 0, 0, 0, 0, 4'h0, 0, 0)};
        tbl[3]  = '{ii(0, 0, 0, 0, 4'h0, 0, 0, 0, 1, 32'h55), zero_o};
        tbl[4]  = '{ii(1, 32'h104, 1, 1, 4'hF, 32'h200, 32'hDEADBEEF, 1, 0, 0),
                    oo(0, 0, 0, 1, 0, 0, 1, 1, 4'hF, 32'h200, 32'hDEADBEEF)};
        tbl[5]  = '{ii(1, 32'h104, 0, 0, 4'h0, 0, 0, 1, 0, 0), zero_o};
        tbl[6]  = '{ii(1, 32'h104, 0, 0, 4'h0, 0, 0, 0, 1, 32'h77),
                    oo(0, 0, 0, 0, 1, 32'h77, 0, 0, 4'h0, 0, 0)};
        tbl[7]  = '{ii(1, 32'h104, 0, 0, 4'h0, 0, 0, 1, 0, 0),
                    oo(1, 0, 0, 0, 0, 0, 1, 0, 4'hF, 32'h104, 0)};
        tbl[8]  = '{ii(0, 0, 0, 0, 4'h0, 0, 0, 0, 1, 32'hABCD),
                    oo(0, 1, 32'hABCD, 0, 0, 0, 0, 0, 4'h0, 0, 0)};
        tbl[9]  = '{ii(0, 0, 0, 0, 4'h0, 0, 0, 0, 0, 0), zero_o};
        tbl[10] = '{ii(0, 0, 1, 0, 4'h3, 32'h400, 32'h12345678, 1, 0, 0),
                    oo(0, 0, 0, 1, 0, 0, 1, 0, 4'h3, 32'h400, 32'h12345678)};
        tbl[11] = '{ii(0, 0, 0, 0, 4'h0, 0, 0, 0, 1, 32'hCAFE),
                    oo(0, 0, 0, 0, 1, 32'hCAFE, 0, 0, 4'h0, 0, 0)};

        do_reset();
        for (int k = 0; k < 12; k++) begin
            cycle(tbl[k].in, mexp);
            check($sformatf("vec%0d", k), last_act, tbl[k].exp);
        end

        // Fairness: both requesters always pending, bus always ready -> LS, LS, IF, ...
        order_exp = '{2'b01, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00,
                      2'b01, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00};
        do_reset();
        for (int k = 0; k < 12; k++) begin
            cycle(ii(1, 32'h600, 1, 1, 4'hF, 32'h500, 32'h1, 1, 1, k), mexp);
            check_val($sformatf("streak_c%0d", k), {last_act.if_gnt, last_act.ls_gnt},
                      order_exp[k]);
        end

        // Stalled bus: IF owner stays locked even after LS asserts.
        do_reset();
        cycle(ii(1, 32'h300, 0, 0, 4'h0, 0, 0, 0, 0, 0), mexp);
        check("hold_c0", last_act, oo(0, 0, 0, 0, 0, 0, 1, 0, 4'hF, 32'h300, 0));
        for (int k = 1; k < 3; k++) begin
            cycle(ii(1, 32'h300, 1, 1, 4'hF, 32'h700, 32'h11112222, 0, 0, 0), mexp);
            check($sformatf("hold_c%0d", k), last_act,
                  oo(0, 0, 0, 0, 0, 0, 1, 0, 4'hF, 32'h300, 0));
        end
        cycle(ii(1, 32'h300, 1, 1, 4'hF, 32'h700, 32'h11112222, 1, 0, 0), mexp);
        check("hold_accept", last_act, oo(1, 0, 0, 0, 0, 0, 1, 0, 4'hF, 32'h300, 0));
        cycle(ii(0, 0, 1, 1, 4'hF, 32'h700, 32'h11112222, 1, 1, 32'h99), mexp);
        check("hold_resp", last_act, oo(0, 1, 32'h99, 0, 0, 0, 0, 0, 4'h0, 0, 0));
        cycle(ii(0, 0, 1, 1, 4'hF, 32'h700, 32'h11112222, 1, 0, 0), mexp);
        check("hold_ls_next", last_act,
              oo(0, 0, 0, 1, 0, 0, 1, 1, 4'hF, 32'h700, 32'h11112222));

        // Reset during WAIT_LS after a full LS streak.
        do_reset();
        cycle(ii(1, 32'h900, 1, 1, 4'hF, 32'h800, 32'h5A5A5A5A, 1, 0, 0), mexp);
        check_val("rst_pre_gnt0", {last_act.if_gnt, last_act.ls_gnt}, 1);
        cycle(ii(1, 32'h900, 1, 1, 4'hF, 32'h800, 32'h5A5A5A5A, 0, 1, 32'h1), mexp);
        cycle(ii(1, 32'h900, 1, 1, 4'hF, 32'h800, 32'h5A5A5A5A, 1, 0, 0), mexp);
        check_val("rst_pre_gnt1", {last_act.if_gnt, last_act.ls_gnt}, 1);
        drive('0);
        #2 rst = 1'b1;
        model_reset();
        @(negedge clk);
        check("rst_mid_outputs", act_w, '0);
        @(posedge clk);
        #1 rst = 1'b0;
        cycle(ii(0, 0, 0, 0, 4'h0, 0, 0, 0, 1, 32'hBAD), mexp);
        check("rst_late_rvalid", last_act, '0);
        cycle(ii(1, 32'h900, 1, 1, 4'hF, 32'h800, 32'h5A5A5A5A, 1, 0, 0), mexp);
        check_val("rst_streak_cleared", {last_act.if_gnt, last_act.ls_gnt}, 1);

        // Protocol violation: held IF drops its request; LS must not be granted that cycle.
        do_reset();
        viol_ok = 1'b1;
        cycle(ii(1, 32'hA00, 0, 0, 4'h0, 0, 0, 0, 0, 0), mexp);
        cycle(ii(0, 0, 1, 0, 4'hF, 32'hB00, 0, 1, 0, 0), mexp);
        check_val("viol_no_gnt", {last_act.if_gnt, last_act.ls_gnt}, 0);
        cycle(ii(0, 0, 1, 0, 4'hF, 32'hB00, 0, 1, 0, 0), mexp);
        check_val("viol_ls_after", {last_act.if_gnt, last_act.ls_gnt}, 1);
        check_val("viol_flagged", n_viol, 1);
        viol_ok = 1'b0;

        // Randomized traffic against the reference model.
        do_reset();
        cur = '0;
        rv_delay = 0;
        for (int n = 0; n < 3000; n++) begin
            if (!(cur.if_req && !(e_acc && e_have && !e_ls))) begin
                cur.if_req  = ($urandom_range(0, 9) < 6);
                cur.if_addr = $urandom & 32'hFFFF_FFFC;
            end
            if (!(cur.ls_req && !(e_acc && e_have && e_ls))) begin
                cur.ls_req   = ($urandom_range(0, 9) < 6);
                cur.ls_we    = 1'($urandom_range(0, 1));
                cur.ls_be    = 4'($urandom);
                cur.ls_addr  = $urandom & 32'hFFFF_FFFC;
                cur.ls_wdata = $urandom;
            end
            if (m_busy) begin
                cur.mem_rvalid = (rv_delay == 0);
                if (rv_delay != 0) rv_delay--;
            end else begin
                cur.mem_rvalid = ($urandom_range(0, 7) == 0);
            end
            cur.mem_gnt   = 1'($urandom_range(0, 1));
            cur.mem_rdata = $urandom;
            cycle(cur, mexp);
            check($sformatf("rand%0d", n), last_act, mexp);
            if (e_have && e_acc) rv_delay = $urandom_range(0, 2);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
